// File: rtl/mult_seq_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package mult_seq_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 5;
   localparam int unsigned PROD_W = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Iteration counter increment built from a half-adder chain, so the block
   // keeps the rca as its only adder.
   function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
      logic [CNT_W-1:0] r;
      logic             c;
      c = 1'b1;
      for (int i = 0; i < CNT_W; i++) begin
         r[i] = v[i] ^ c;
         c    = c & v[i];
      end
      return r;
   endfunction

endpackage

// File: rtl/rca.sv
// 32-bit ripple-carry adder: sum = a + b + ci, carry out on co.
module rca (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        ci,
   output logic        co,
   output logic [31:0] sum
);

   // Carry ripples LSB to MSB through a block-local variable.
   always_comb begin
      logic c;
      c   = ci;
      sum = '0;
      for (int i = 0; i < 32; i++) begin
         sum[i] = a[i] ^ b[i] ^ c;
         c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      co = c;
   end

endmodule

// File: rtl/mult_seq.sv
// Sequential 32x32 -> 64 multiplier, one shift-add iteration per cycle through
// a single shared rca. Define MULT_SEQ_SIGNED_EN to add the signed_op port and
// two's-complement operation (mode latched at accept).
module mult_seq
   import mult_seq_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
`ifdef MULT_SEQ_SIGNED_EN
   input  logic              signed_op,
`endif
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PROD_W-1:0] product,
   output logic              busy
);

   state_e            state;
   logic [DATA_W-1:0] mcand;
   logic [DATA_W-1:0] hi;
   logic [DATA_W-1:0] lo;
   logic [CNT_W-1:0]  cnt;
   logic              ready_r;
   logic              valid_r;
   logic              busy_r;

`ifdef MULT_SEQ_SIGNED_EN
   logic              signed_mode;
`else
   logic              signed_mode;
   assign signed_mode = 1'b0;
`endif

   logic              last_cyc;
   logic              add_cyc;
   logic              sub_cyc;
   logic [DATA_W-1:0] op2;
   logic              ci;
   logic              co;
   logic [DATA_W-1:0] sum;
   logic              ext;

   assign last_cyc = &cnt;

   // One iteration: pick the addend, then form the bit shifted into hi[31].
   always_comb begin
      add_cyc = lo[0];
      sub_cyc = signed_mode & last_cyc & lo[0];
      ci      = sub_cyc;
      if (sub_cyc) begin
         op2 = ~mcand;
      end else if (add_cyc) begin
         op2 = mcand;
      end else begin
         op2 = '0;
      end
      if (signed_mode) begin
         // Sign bit of the 33-bit sum of sign-extended operands.
         ext = add_cyc ? (hi[DATA_W-1] ^ op2[DATA_W-1] ^ co) : hi[DATA_W-1];
      end else begin
         ext = add_cyc ? co : 1'b0;
      end
   end

   rca u_rca (
      .a  (hi),
      .b  (op2),
      .ci (ci),
      .co (co),
      .sum(sum)
   );

   // Control FSM and datapath registers; handshake outputs are registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         hi      <= '0;
         lo      <= '0;
         mcand   <= '0;
         ready_r <= 1'b1;
         valid_r <= 1'b0;
         busy_r  <= 1'b0;
`ifdef MULT_SEQ_SIGNED_EN
         signed_mode <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  mcand   <= a;
                  hi      <= '0;
                  lo      <= b;
                  cnt     <= '0;
                  state   <= RUN;
                  ready_r <= 1'b0;
                  busy_r  <= 1'b1;
`ifdef MULT_SEQ_SIGNED_EN
                  signed_mode <= signed_op;
`endif
               end
            end
            RUN: begin
               hi  <= {ext, sum[DATA_W-1:1]};
               lo  <= {sum[0], lo[DATA_W-1:1]};
               cnt <= cnt_inc(cnt);
               if (last_cyc) begin
                  state   <= DONE;
                  valid_r <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state   <= IDLE;
                  valid_r <= 1'b0;
                  busy_r  <= 1'b0;
                  ready_r <= 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               ready_r <= 1'b1;
               valid_r <= 1'b0;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   // Reset is synchronous, so ready is masked directly while rst is high.
   assign in_ready  = ready_r & ~rst;
   assign out_valid = valid_r;
   assign busy      = busy_r;
   assign product   = {hi, lo};

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq: vector table plus handshake/reset corners.
module tb_mult_seq;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] product;
   logic        busy;
`ifdef MULT_SEQ_SIGNED_EN
   logic        signed_op;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   mult_seq dut (
      .clk      (clk),
      .rst      (rst),
`ifdef MULT_SEQ_SIGNED_EN
      .signed_op(signed_op),
`endif
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .product  (product),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] va;
      logic [31:0] vb;
      logic        sgn;
      logic [63:0] exp;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int t;
      t = 0;
      while (!in_ready && t < 100) begin
         next_cyc();
         t++;
      end
      chk("wait_ready", 64'(in_ready), 64'd1);
   endtask

   // Full transaction with out_ready high: checks 32-edge latency and product.
   task automatic do_op(input logic [31:0] ta, input logic [31:0] tb2, input logic sgn,
                        input logic [63:0] exp, input string nm);
      int lat;
      wait_ready();
      a        = ta;
      b        = tb2;
      in_valid = 1'b1;
`ifdef MULT_SEQ_SIGNED_EN
      signed_op = sgn;
`else
      if (sgn) $display("note: signed vector skipped in unsigned build");
`endif
      next_cyc();
      in_valid = 1'b0;
      lat      = 0;
      while (!out_valid && lat < 40) begin
         next_cyc();
         lat++;
      end
      chk({nm, "_latency"}, 64'(lat), 64'd32);
      chk({nm, "_product"}, product, exp);
      next_cyc();
   endtask

   vec_t vecs[$];
   vec_t tp[3];

   initial begin
      int lat;
      int cnt_ov;
      int c;
      int prev;
      int n_acc;
      int n_done;

      rst       = 1'b1;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      out_ready = 1'b1;
`ifdef MULT_SEQ_SIGNED_EN
      signed_op = 1'b0;
`endif

      // Reset state
      next_cyc();
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_product", product, 64'd0);
      next_cyc();
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", 64'(in_ready), 64'd1);

      // Directed vector table
      vecs.push_back('{32'd3, 32'd5, 1'b0, 64'h0000_0000_0000_000F});
      vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001});
      vecs.push_back('{32'd0, 32'hDEAD_BEEF, 1'b0, 64'd0});
      vecs.push_back('{32'd1, 32'hFFFF_FFFF, 1'b0, 64'h0000_0000_FFFF_FFFF});
      vecs.push_back('{32'h8000_0000, 32'd2, 1'b0, 64'h0000_0001_0000_0000});
      vecs.push_back('{32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 64'h0000_0000_FFFE_0001});
      vecs.push_back('{32'd1000, 32'd1000, 1'b0, 64'd1000000});
      vecs.push_back('{32'h1234_5678, 32'h10, 1'b0, 64'h0000_0001_2345_6780});
`ifdef MULT_SEQ_SIGNED_EN
      vecs.push_back('{32'hFFFF_FFFD, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1});
      vecs.push_back('{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000});
      vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'd1});
      vecs.push_back('{32'd7, 32'hFFFF_FFFE, 1'b1, 64'hFFFF_FFFF_FFFF_FFF2});
`endif
      foreach (vecs[i]) begin
         do_op(vecs[i].va, vecs[i].vb, vecs[i].sgn, vecs[i].exp, $sformatf("vec%0d", i));
      end

      // Back-pressure in DONE with in_valid pulses that must be ignored
      wait_ready();
      a         = 32'd11;
      b         = 32'd13;
      in_valid  = 1'b1;
      out_ready = 1'b0;
`ifdef MULT_SEQ_SIGNED_EN
      signed_op = 1'b0;
`endif
      next_cyc();
      a   = 32'd9;
      b   = 32'd9;
      lat = 0;
      while (!out_valid && lat < 40) begin
         in_valid = ~in_valid;
         next_cyc();
         lat++;
      end
      chk("bp_latency", 64'(lat), 64'd32);
      for (int i = 0; i < 10; i++) begin
         chk("bp_out_valid", 64'(out_valid), 64'd1);
         chk("bp_product", product, 64'd143);
         chk("bp_in_ready", 64'(in_ready), 64'd0);
         in_valid = ~in_valid;
         next_cyc();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      next_cyc();
      chk("bp_release_valid", 64'(out_valid), 64'd0);
      chk("bp_release_ready", 64'(in_ready), 64'd1);
      chk("bp_release_busy", 64'(busy), 64'd0);

      // Reset mid-run at cnt=10 aborts without an out_valid pulse
      wait_ready();
      a        = 32'h0000_FFFF;
      b        = 32'h0000_FFFF;
      in_valid = 1'b1;
      next_cyc();
      in_valid = 1'b0;
      repeat (10) next_cyc();
      rst = 1'b1;
      #1;
      chk("abort_rst_in_ready", 64'(in_ready), 64'd0);
      next_cyc();
      rst = 1'b0;
      #1;
      chk("abort_in_ready", 64'(in_ready), 64'd1);
      chk("abort_out_valid", 64'(out_valid), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_product", product, 64'd0);
      cnt_ov = 0;
      for (int i = 0; i < 40; i++) begin
         next_cyc();
         if (out_valid) cnt_ov++;
      end
      chk("abort_no_out_valid", 64'(cnt_ov), 64'd0);
      do_op(32'd7, 32'd6, 1'b0, 64'd42, "after_abort");

      // Back-to-back: in_valid and out_ready held high
      tp[0] = '{32'd5, 32'd7, 1'b0, 64'd35};
      tp[1] = '{32'h0001_0000, 32'h0001_0000, 1'b0, 64'h0000_0001_0000_0000};
      tp[2] = '{32'hFFFF_FFFF, 32'd2, 1'b0, 64'h0000_0001_FFFF_FFFE};
      wait_ready();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      a         = tp[0].va;
      b         = tp[0].vb;
      prev      = -1;
      n_acc     = 0;
      n_done    = 0;
      c         = 0;
      while (n_done < 3 && c < 200) begin
         if (out_valid) begin
            chk($sformatf("b2b_product%0d", n_done), product, tp[n_done].exp);
            n_done++;
         end
         if (in_ready && in_valid) begin
            if (prev >= 0) chk("b2b_spacing", 64'(c - prev), 64'd34);
            prev = c;
            n_acc++;
         end
         next_cyc();
         c++;
         if (n_acc >= 3) begin
            in_valid = 1'b0;
         end else begin
            a = tp[n_acc].va;
            b = tp[n_acc].vb;
         end
      end
      chk("b2b_done_count", 64'(n_done), 64'd3);
      chk("b2b_accept_count", 64'(n_acc), 64'd3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mult_seq.md
MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: in_valid  input  1  operands a/b are presented.
REQ-004 SHALL have port: in_ready  output  1  block accepts operands this cycle.
REQ-005 SHALL have port: a  input  32  multiplicand.
REQ-006 SHALL have port: b  input  32  multiplier.
REQ-007 SHALL have port: out_valid  output  1  product is valid.
REQ-008 SHALL have port: out_ready  input  1  consumer takes product this cycle.
REQ-009 SHALL have port: product  output  64  result a*b.
REQ-010 SHALL have port: busy  output  1  high in RUN or DONE.
REQ-011 SHALL have port, only with MULT_SEQ_SIGNED_EN defined: signed_op  input  1  sampled at accept; 1 = two's-complement operands.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-013 SHALL drive in_ready=1 only in IDLE.
REQ-014 SHALL drive out_valid=1 only in DONE.
REQ-015 SHALL drive busy=1 in RUN and DONE.
REQ-016 Accept (in_valid && in_ready) SHALL load the registers and go to RUN: mcand=a, hi=0, lo=b, cnt=0.
REQ-017 Each RUN cycle SHALL perform one iteration through a single 32-bit adder: operand2=mcand if lo[0]=1, else 0; {hi,lo} shifts right 1; new hi = {ext, sum[31:1]}; new lo = {sum[0], lo[31:1]}.
REQ-018 Unsigned mode SHALL set ext = adder co on add cycles and 0 on non-add cycles.
REQ-019 Signed mode, cnt=31 with lo[0]=1, SHALL subtract: operand2=~mcand, ci=1.
REQ-020 Signed mode SHALL set ext = hi[31]^op2[31]^co on add/sub cycles and hi[31] otherwise.
REQ-021 All non-subtract cycles SHALL use ci=0.
REQ-022 cnt SHALL increment each RUN cycle; the cycle with cnt=31 SHALL transition to DONE.
REQ-023 out_valid SHALL rise exactly 32 clock edges after the accepting edge.
REQ-024 In DONE, product={hi,lo} SHALL be held stable until out_valid && out_ready; that edge SHALL return to IDLE.
REQ-025 in_valid, a, b SHALL be ignored outside IDLE; no overlap of operations.
REQ-026 Minimum accept-to-accept spacing SHALL be 34 cycles: 32 RUN, 1 DONE with out_ready=1, 1 IDLE.

Reset
REQ-027 rst SHALL force on the next edge: state=IDLE, cnt=0, hi=0, lo=0, mcand=0.
REQ-028 While rst is high, in_ready SHALL be 0.
REQ-029 After the first edge with rst high, out_valid=0, busy=0, product=0.
REQ-030 rst in RUN or DONE SHALL abort the operation with no out_valid pulse.
REQ-031 rst SHALL take priority over an accept or output handshake in the same cycle.

Configuration
REQ-032 Macro MULT_SEQ_SIGNED_EN defined SHALL add port signed_op and the signed behaviour of REQ-019/REQ-020, with the mode latched at accept.
REQ-033 Macro MULT_SEQ_SIGNED_EN undefined SHALL make the block unsigned only and omit signed_op.

Structure
REQ-034 Package mult_seq_pkg SHALL hold: state enum type (IDLE/RUN/DONE), DATA_W=32, CNT_W=5, PROD_W=64.
REQ-035 The block SHALL instantiate exactly one rca (existing 32-bit ripple-carry adder: a, b, ci, co, sum) as the shared datapath adder.
REQ-036 The block SHALL contain no other arithmetic operators.

Verification
REQ-037 Bench SHALL cover: a=3, b=5 accepted at edge k -> out_valid at edge k+32, product=0x0000_0000_0000_000F.
REQ-038 Bench SHALL cover: unsigned a=b=0xFFFF_FFFF -> product=0xFFFF_FFFE_0000_0001.
REQ-039 Bench SHALL cover, with MULT_SEQ_SIGNED_EN: signed a=-3, b=5 -> 0xFFFF_FFFF_FFFF_FFF1; a=b=0x8000_0000 -> 0x4000_0000_0000_0000; a=-1, b=-1 -> 1.
REQ-040 Bench SHALL cover: out_ready low 10 cycles in DONE -> out_valid and product held, in_ready=0; in_valid pulses with a=9 during RUN/DONE not accepted.
REQ-041 Bench SHALL cover: rst at cnt=10 -> next cycle in_ready=1, out_valid=0, busy=0; then a=7, b=6 -> product=42.
REQ-042 Bench SHALL cover: in_valid held high, out_ready held high -> accepts exactly 34 cycles apart, each product correct.
